// File: rtl/i2s_rx_multi_if.sv
// Pin and result bundle for the multi-format I2S receiver.
// The slave side is the receiver; the master side drives the serial pins and reads the results.
interface i2s_rx_multi_if #(
  parameter int DATA_W     = 16,
  parameter int MAX_SLOT_W = 32
);
  localparam int CNT_W = $clog2(MAX_SLOT_W + 1);

  logic                     sck;
  logic                     ws;
  logic                     sd;
  logic [1:0]               fmt;
  logic signed [DATA_W-1:0] left_out;
  logic signed [DATA_W-1:0] right_out;
  logic                     sample_valid;
  logic [CNT_W-1:0]         slot_bits;
  logic                     frame_err;

  modport master (
    output sck, ws, sd, fmt,
    input  left_out, right_out, sample_valid, slot_bits, frame_err
  );

  modport slave (
    input  sck, ws, sd, fmt,
    output left_out, right_out, sample_valid, slot_bits, frame_err
  );
endinterface

// File: rtl/i2s_rx_multi.sv
// Oversampling I2S / left-justified / right-justified stereo receiver with paired output strobe.
// Define I2S_RX_FRAME_CHECK_EN to enable the sticky left/right slot-length check on frame_err.
module i2s_rx_multi #(
  parameter int DATA_W      = 16,
  parameter int MAX_SLOT_W  = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  i2s_rx_multi_if.slave bus
);
  // state   | meaning
  // ST_IDLE | no edge event seen since reset, ws history invalid
  // ST_SYNC | ws history valid, waiting for first ws transition
  // ST_RUN  | armed: slots are decoded and closed

  localparam int CNT_W = $clog2(MAX_SLOT_W + 1);
  localparam int CAP_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SLOT_W);
  localparam logic [CAP_W-1:0] CAP_FULL = CAP_W'(DATA_W);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic              sck_s, ws_s, sd_s, sck_d, ws_prev;
  logic              edge_ev, ws_trans, close_left, close_right;
  logic [1:0]        fmt_in, fmt_q;
  logic [DATA_W-1:0] shreg, hold, word, left_q, right_q;
  logic [CAP_W-1:0]  ncap;
  logic [CNT_W-1:0]  cnt, slot_cnt, bits_q;
  logic              left_ok, valid_q;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ws_s     = ws_sync[SYNC_STAGES-1];
  assign sd_s     = sd_sync[SYNC_STAGES-1];
  assign edge_ev  = sck_s & ~sck_d;
  assign ws_trans = edge_ev & (state != ST_IDLE) & (ws_s != ws_prev);
  assign fmt_in   = (bus.fmt == 2'b11) ? 2'b00 : bus.fmt;
  assign slot_cnt = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

  // Justified formats capture MSB-first, so a short slot leaves the word right-aligned in shreg.
  always_comb begin
    word = shreg;
    if (fmt_q != 2'b10) word = shreg << (CAP_FULL - ncap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], bus.ws};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], bus.sd};
      sck_d    <= sck_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    close_left  = 1'b0;
    close_right = 1'b0;
    case (state)
      ST_IDLE: if (edge_ev) state_nxt = ST_SYNC;
      ST_SYNC: if (ws_trans) state_nxt = ST_RUN;
      ST_RUN: begin
        close_left  = ws_trans & ~ws_prev;
        close_right = ws_trans & ws_prev;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_prev <= 1'b0;
      fmt_q   <= 2'b00;
      cnt     <= '0;
      shreg   <= '0;
      ncap    <= '0;
    end else if (edge_ev) begin
      ws_prev <= ws_s;
      if (ws_trans) begin
        fmt_q <= fmt_in;
        cnt   <= '0;
        shreg <= (fmt_in == 2'b00) ? '0 : DATA_W'(sd_s);
        ncap  <= (fmt_in == 2'b00) ? '0 : CAP_W'(1);
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        // Right-justified keeps shifting so the last DATA_W bits win.
        if (fmt_q == 2'b10 || ncap != CAP_FULL) begin
          shreg <= {shreg[DATA_W-2:0], sd_s};
          if (ncap != CAP_FULL) ncap <= ncap + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= '0;
      left_ok <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      bits_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (close_left) begin
        hold    <= word;
        left_ok <= 1'b1;
      end
      if (close_right) begin
        left_ok <= 1'b0;
        if (left_ok) begin
          left_q  <= hold;
          right_q <= word;
          bits_q  <= slot_cnt;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.left_out     = left_q;
  assign bus.right_out    = right_q;
  assign bus.slot_bits    = bits_q;
  assign bus.sample_valid = valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
  logic [CNT_W-1:0] left_cnt;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (close_left) left_cnt <= slot_cnt;
      if (close_right && (!left_ok || left_cnt != slot_cnt)) err_q <= 1'b1;
    end
  end

  assign bus.frame_err = err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Self-checking bench for i2s_rx_multi: directed vector table, reset sequence and randomized frames.
module tb_i2s_rx_multi;
  localparam int DW = 16;
  localparam int MS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_rx_multi_if #(.DATA_W(DW), .MAX_SLOT_W(MS)) bus ();

  i2s_rx_multi #(.DATA_W(DW), .MAX_SLOT_W(MS), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic ws; int n; logic [63:0] pay; } slot_t;
  typedef struct { logic [15:0] l; logic [15:0] r; logic [5:0] b; } pair_t;
  typedef struct {
    logic [1:0] fmt; int nl; int nr; logic [63:0] lpay; logic [63:0] rpay;
    logic [15:0] el; logic [15:0] er; logic [5:0] eb; logic ee;
  } vec_t;

  slot_t slots[$];
  pair_t rx_q[$];
  pair_t exp_q[$];
  vec_t  vecs[8];
  int    n_cmp = 0;
  int    n_mis = 0;
  int    dbl_cnt = 0;
  logic  prev_v = 1'b0;

  always @(negedge clk) begin
    if (bus.sample_valid) begin
      rx_q.push_back('{$unsigned(bus.left_out), $unsigned(bus.right_out), bus.slot_bits});
      if (prev_v) dbl_cnt++;
    end
    prev_v = bus.sample_valid;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word the receiver should produce for one slot: edge k carries pay[n-1-k].
  function automatic logic [15:0] ref_word(input logic [1:0] f, input int n, input logic [63:0] pay);
    logic [15:0] w;
    int k;
    w = '0;
    for (int b = 0; b < DW; b++) begin
      if (f == 2'b10)      k = n - 1 - b;
      else if (f == 2'b01) k = DW - 1 - b;
      else                 k = DW - b;
      if (k >= 0 && k < n) w[b] = pay[n-1-k];
    end
    return w;
  endfunction

  task automatic sck_edge(input logic w, input logic d);
    bus.ws = w;
    bus.sd = d;
    repeat (4) @(negedge clk);
    bus.sck = 1'b1;
    repeat (4) @(negedge clk);
    bus.sck = 1'b0;
  endtask

  task automatic drive_slots(input logic terminate);
    logic last_ws;
    last_ws = 1'b0;
    foreach (slots[i]) begin
      for (int k = 0; k < slots[i].n; k++) sck_edge(slots[i].ws, slots[i].pay[slots[i].n-1-k]);
      last_ws = slots[i].ws;
    end
    if (terminate) sck_edge(~last_ws, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sck = 1'b0;
    bus.ws  = 1'b0;
    bus.sd  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_q.delete();
  endtask

  task automatic cmp_pairs(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_left"},  rx_q[i].l, exp_q[i].l);
      check({tag, "_right"}, rx_q[i].r, exp_q[i].r);
      check({tag, "_bits"},  rx_q[i].b, exp_q[i].b);
    end
  endtask

  task automatic run_random();
    logic [1:0]  f;
    logic        w, lok, err;
    logic [15:0] hold, wd;
    int          c, lc;
    f = 2'($urandom_range(0, 3));
    do_reset();
    bus.fmt = f;
    slots.delete();
    w = 1'($urandom_range(0, 1));
    slots.push_back('{w, int'($urandom_range(3, 10)), {$urandom, $urandom}});
    for (int i = 0; i < 10; i++) begin
      w = ~w;
      slots.push_back('{w, int'($urandom_range(8, 40)), {$urandom, $urandom}});
    end
    exp_q.delete();
    lok = 1'b0; err = 1'b0; hold = '0; lc = 0;
    for (int i = 1; i < slots.size(); i++) begin
      wd = ref_word(f, slots[i].n, slots[i].pay);
      c  = (slots[i].n > MS) ? MS : slots[i].n;
      if (!slots[i].ws) begin
        hold = wd; lok = 1'b1; lc = c;
      end else begin
        if (!lok || lc != c) err = 1'b1;
        if (lok) exp_q.push_back('{hold, wd, 6'(c)});
        lok = 1'b0;
      end
    end
    drive_slots(1'b1);
    cmp_pairs("rand");
`ifdef I2S_RX_FRAME_CHECK_EN
    check("rand_frame_err", bus.frame_err, err);
`else
    check("rand_frame_err", bus.frame_err, 1'b0);
`endif
  endtask

  initial begin
    vecs[0] = '{2'b00, 32, 32, 64'h4000_8000, 64'h3FFF_0000, 16'h8001, 16'h7FFE, 6'd32, 1'b0};
    vecs[1] = '{2'b01, 32, 32, 64'h8001_0000, 64'h7FFE_0000, 16'h8001, 16'h7FFE, 6'd32, 1'b0};
    vecs[2] = '{2'b01, 32, 32, 64'h4000_8000, 64'h3FFF_0000, 16'h4000, 16'h3FFF, 6'd32, 1'b0};
    vecs[3] = '{2'b10, 24, 24, 64'h00_1234, 64'h00_ABCD, 16'h1234, 16'hABCD, 6'd24, 1'b0};
    vecs[4] = '{2'b00, 12, 12, 64'hFFF, 64'h555, 16'hFFE0, 16'hAAA0, 6'd12, 1'b0};
    vecs[5] = '{2'b10, 10, 10, 64'h3FF, 64'h200, 16'h03FF, 16'h0200, 6'd10, 1'b0};
    vecs[6] = '{2'b00, 40, 40, 64'hBEEF << 23, 64'h1234 << 23, 16'hBEEF, 16'h1234, 6'd32, 1'b0};
    vecs[7] = '{2'b11, 32, 31, 64'h4000_8000, 64'h7FFE << 14, 16'h8001, 16'h7FFE, 6'd31, 1'b1};

    bus.fmt = 2'b00;
    do_reset();
    check("reset_left", $unsigned(bus.left_out), 16'h0);
    check("reset_right", $unsigned(bus.right_out), 16'h0);
    check("reset_bits", bus.slot_bits, 6'd0);
    check("reset_valid", bus.sample_valid, 1'b0);
    check("reset_err", bus.frame_err, 1'b0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      bus.fmt = vecs[v].fmt;
      slots.delete();
      slots.push_back('{1'b1, 5, 64'h0});
      for (int fr = 0; fr < 2; fr++) begin
        slots.push_back('{1'b0, vecs[v].nl, vecs[v].lpay});
        slots.push_back('{1'b1, vecs[v].nr, vecs[v].rpay});
      end
      drive_slots(1'b1);
      exp_q.delete();
      repeat (2) exp_q.push_back('{vecs[v].el, vecs[v].er, vecs[v].eb});
      cmp_pairs($sformatf("vec%0d", v));
`ifdef I2S_RX_FRAME_CHECK_EN
      check($sformatf("vec%0d_frame_err", v), bus.frame_err, vecs[v].ee);
`else
      check($sformatf("vec%0d_frame_err", v), bus.frame_err, 1'b0);
`endif
      repeat (60) @(negedge clk);
      check($sformatf("vec%0d_idle_left", v), $unsigned(bus.left_out), vecs[v].el);
      check($sformatf("vec%0d_idle_count", v), rx_q.size(), 2);
    end

    // Reset in the middle of a right slot, then resume the stream.
    do_reset();
    bus.fmt = 2'b00;
    slots.delete();
    slots.push_back('{1'b1, 5, 64'h0});
    slots.push_back('{1'b0, 32, 64'h4000_8000});
    slots.push_back('{1'b1, 32, 64'h3FFF_0000});
    slots.push_back('{1'b0, 32, 64'h1234_5678});
    slots.push_back('{1'b1, 10, 64'h3FF});
    drive_slots(1'b0);
    check("midrst_pre_count", rx_q.size(), 1);
    rst = 1'b1;
    #1;
    check("midrst_left", $unsigned(bus.left_out), 16'h0);
    check("midrst_right", $unsigned(bus.right_out), 16'h0);
    check("midrst_bits", bus.slot_bits, 6'd0);
    check("midrst_valid", bus.sample_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    slots.delete();
    slots.push_back('{1'b1, 22, 64'h2A_AAAA});
    slots.push_back('{1'b0, 32, 64'h5555_0000});
    slots.push_back('{1'b1, 32, 64'h0F0F_F0F0});
    drive_slots(1'b1);
    exp_q.delete();
    exp_q.push_back('{ref_word(2'b00, 32, 64'h5555_0000), ref_word(2'b00, 32, 64'h0F0F_F0F0), 6'd32});
    cmp_pairs("midrst");
    check("midrst_err", bus.frame_err, 1'b0);

    for (int r = 0; r < 4; r++) run_random();

    check("strobe_width", dbl_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
